// File: rtl/alu_cmd_sequencer.sv
// Collects A, B and op bytes from a byte stream, drives an external combinational ALU,
// and presents the registered result on a valid/ready handshake.
module alu_cmd_sequencer #(
    parameter int unsigned MAX_OP = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [7:0] alu_result,
    input  logic       alu_cout,
    output logic [7:0] out_result,
    output logic       out_cout,
    output logic       out_zero,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err_op,
    output logic [7:0] cmd_count
);

    typedef enum logic [2:0] {GET_A, GET_B, GET_OP, EXEC, HOLD} state_t;

    localparam logic [7:0] MaxOpByte = 8'(MAX_OP);

    state_t state_q;

    // Input side is open in every collecting state, independent of the result handshake.
    assign in_ready = (state_q == GET_A) || (state_q == GET_B) || (state_q == GET_OP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= GET_A;
            alu_a      <= 8'd0;
            alu_b      <= 8'd0;
            alu_sel    <= 3'd0;
            out_result <= 8'd0;
            out_cout   <= 1'b0;
            out_zero   <= 1'b0;
            out_valid  <= 1'b0;
            err_op     <= 1'b0;
            cmd_count  <= 8'd0;
        end else begin
            err_op <= 1'b0;
            case (state_q)
                GET_A: begin
                    if (in_valid) begin
                        alu_a   <= in_data;
                        state_q <= GET_B;
                    end
                end
                GET_B: begin
                    if (in_valid) begin
                        alu_b   <= in_data;
                        state_q <= GET_OP;
                    end
                end
                GET_OP: begin
                    if (in_valid) begin
                        if (in_data <= MaxOpByte) begin
                            alu_sel <= in_data[2:0];
                            state_q <= EXEC;
                        end else begin
                            // Illegal op: drop the whole command, keep the previous select.
                            err_op  <= 1'b1;
                            state_q <= GET_A;
                        end
                    end
                end
                EXEC: begin
                    out_result <= alu_result;
                    out_cout   <= alu_cout;
                    out_zero   <= (alu_result == 8'd0);
                    out_valid  <= 1'b1;
                    state_q    <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        cmd_count <= cmd_count + 8'd1;
                        state_q   <= GET_A;
                    end
                end
                default: state_q <= GET_A;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU (0 add, 1 sub, 2 and, 3 or).
module tb_alu_cmd_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_result;
    logic       alu_cout;
    logic [7:0] out_result;
    logic       out_cout;
    logic       out_zero;
    logic       out_valid;
    logic       out_ready;
    logic       err_op;
    logic [7:0] cmd_count;

    int total = 0;
    int bad   = 0;

    alu_cmd_sequencer #(.MAX_OP(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .alu_cout   (alu_cout),
        .out_result (out_result),
        .out_cout   (out_cout),
        .out_zero   (out_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err_op     (err_op),
        .cmd_count  (cmd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        alu_result = 8'd0;
        alu_cout   = 1'b0;
        case (alu_sel)
            3'd0: {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1: {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            default: alu_result = 8'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    // Sends a full command, checks latency and result, then completes the handshake.
    task automatic do_cmd(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] op, input logic [7:0] exp_res, input logic exp_c,
                          input logic exp_z, input logic [7:0] exp_cnt);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        chk({tag, "_valid_n1"}, out_valid, 1'b0);
        tick();
        chk({tag, "_valid_n2"}, out_valid, 1'b1);
        chk({tag, "_res"}, {out_result, out_cout, out_zero}, {exp_res, exp_c, exp_z});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_done"}, {out_valid, in_ready, cmd_count}, {1'b0, 1'b1, exp_cnt});
    endtask

    logic [38:0] snap;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("reset_outputs",
            {alu_a, alu_b, alu_sel, out_result, out_cout, out_zero, out_valid, err_op, cmd_count},
            39'd0);
        rst_n = 1'b1;
        chk("reset_in_ready", in_ready, 1'b1);

        // 200 + 100 with a stalled consumer.
        send_byte(8'd200);
        send_byte(8'd100);
        send_byte(8'd0);
        chk("add_operands", {alu_a, alu_b, alu_sel, out_valid}, {8'd200, 8'd100, 3'd0, 1'b0});
        tick();
        chk("add_valid", out_valid, 1'b1);
        chk("add_res", {out_result, out_cout, out_zero}, {8'd44, 1'b1, 1'b0});
        snap = {out_valid, out_result, out_cout, out_zero, in_ready, cmd_count, 19'd0};
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("hold_stable", {out_valid, out_result, out_cout, out_zero, in_ready, cmd_count,
                                19'd0}, {1'b1, 8'd44, 1'b1, 1'b0, 1'b0, 8'd0, 19'd0});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold_handshake", {out_valid, in_ready, cmd_count}, {1'b0, 1'b1, 8'd1});
        tick();
        chk("no_double_count", cmd_count, 8'd1);

        do_cmd("sub", 8'd5, 8'd7, 8'd1, 8'd254, 1'b0, 1'b0, 8'd2);
        do_cmd("and", 8'h0F, 8'hF0, 8'd2, 8'd0, 1'b0, 1'b1, 8'd3);

        // Illegal op: alu_sel stays at the previous legal value (2).
        send_byte(8'd1);
        send_byte(8'd2);
        send_byte(8'd7);
        chk("err_pulse", {err_op, out_valid, alu_sel, in_ready}, {1'b1, 1'b0, 3'd2, 1'b1});
        tick();
        chk("err_clear", {err_op, out_valid}, {1'b0, 1'b0});
        send_byte(8'd9);
        chk("err_next_is_a", alu_a, 8'd9);
        send_byte(8'd1);
        send_byte(8'd0);
        tick();
        chk("err_recover", {out_valid, out_result, out_cout}, {1'b1, 8'd10, 1'b0});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("err_recover_cnt", cmd_count, 8'd4);

        // Asynchronous reset after the B byte.
        send_byte(8'd11);
        send_byte(8'd22);
        rst_n = 1'b0;
        #2;
        chk("midreset_outputs",
            {alu_a, alu_b, alu_sel, out_result, out_cout, out_zero, out_valid, err_op, cmd_count},
            39'd0);
        tick();
        rst_n = 1'b1;
        chk("midreset_in_ready", in_ready, 1'b1);
        do_cmd("or_after_reset", 8'd3, 8'd4, 8'd3, 8'd7, 1'b0, 1'b0, 8'd1);

        // 255 more commands bring the counter through 255 back to 0.
        for (int i = 0; i < 255; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            logic [8:0] s;
            a = 8'(i);
            b = 8'(i * 3);
            s = {1'b0, a} + {1'b0, b};
            send_byte(a);
            send_byte(b);
            send_byte(8'd0);
            tick();
            chk("wrap_res", {out_valid, out_result, out_cout}, {1'b1, s[7:0], s[8]});
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            if (i == 253) chk("count_255", cmd_count, 8'd255);
        end
        chk("count_wrap", cmd_count, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter MAX_OP, default 3, meaning the highest legal operation code.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_data, input, 8 bits: command byte stream, in the order A, B, op.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-007 The block SHALL have ports alu_a and alu_b, output, 8 bits each: registered operands driven to the ALU.
REQ-008 The block SHALL have port alu_sel, output, 3 bits: registered operation select driven to the ALU.
REQ-009 The block SHALL have ports alu_result (input, 8 bits) and alu_cout (input, 1 bit): the combinational ALU response.
REQ-010 The block SHALL have ports out_result (output, 8 bits), out_cout (output, 1 bit) and out_zero (output, 1 bit): the registered result, carry and zero flag.
REQ-011 The block SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: the result handshake.
REQ-012 The block SHALL have port err_op, output, 1 bit: one-cycle pulse on an illegal op byte.
REQ-013 The block SHALL have port cmd_count, output, 8 bits: count of completed result handshakes.

Function
REQ-014 The FSM SHALL have states GET_A, GET_B, GET_OP, EXEC and HOLD.
REQ-015 in_ready SHALL be 1 in GET_A, GET_B and GET_OP, and 0 in EXEC and HOLD.
REQ-016 An input transfer SHALL occur only when in_valid=1 and in_ready=1; with in_valid=0 the state SHALL be held indefinitely.
REQ-017 A GET_A transfer SHALL load alu_a from in_data and move to GET_B.
REQ-018 A GET_B transfer SHALL load alu_b from in_data and move to GET_OP.
REQ-019 A GET_OP transfer with in_data <= MAX_OP SHALL load alu_sel from in_data[2:0] and move to EXEC.
REQ-020 A GET_OP transfer with in_data > MAX_OP SHALL pulse err_op for exactly the next cycle, leave alu_sel unchanged, discard the command, return to GET_A and leave out_valid low.
REQ-021 In EXEC, the block SHALL register alu_result into out_result, alu_cout into out_cout, and (alu_result == 0) into out_zero, set out_valid and move to HOLD; EXEC SHALL last exactly one cycle.
REQ-022 Latency: when the op byte is accepted at edge N, out_valid SHALL be 1 from edge N+2.
REQ-023 In HOLD, out_valid, out_result, out_cout and out_zero SHALL remain stable until out_valid=1 and out_ready=1 at a clock edge.
REQ-024 On that HOLD handshake edge, out_valid SHALL clear, cmd_count SHALL increment by 1 and the FSM SHALL move to GET_A.
REQ-025 cmd_count SHALL wrap from 255 to 0 without a flag.
REQ-026 out_ready SHALL be ignored whenever out_valid=0.
REQ-027 out_valid SHALL never depend combinationally on out_ready.
REQ-028 alu_a, alu_b and alu_sel SHALL keep their values after a command until the next transfer overwrites them.
REQ-029 Maximum throughput SHALL be one command per 5 cycles: 3 input cycles, 1 EXEC cycle and at least 1 HOLD cycle.

Reset
REQ-030 While rst_n=0, and immediately and asynchronously on its assertion, the FSM SHALL return to GET_A.
REQ-031 In reset, alu_a, alu_b, alu_sel, out_result, out_cout, out_zero, out_valid, err_op and cmd_count SHALL all be 0.
REQ-032 Reset asserted mid-command or in HOLD SHALL discard the partial command or the pending result with no handshake and no count increment.
REQ-033 in_ready SHALL be 1 on the first cycle after rst_n deasserts.

Verification
REQ-034 Bench: bytes 200, 100, 0 back-to-back -> out_result=44, out_cout=1, out_zero=0, out_valid exactly 2 cycles after op accept.
REQ-035 Bench: bytes 5, 7, 1 -> out_result=254, out_cout=0, out_zero=0; bytes 0x0F, 0xF0, 2 -> out_result=0, out_zero=1.
REQ-036 Bench: bytes 1, 2, 7 with MAX_OP=3 -> err_op high for one cycle, no out_valid, alu_sel unchanged, next byte is taken as A.
REQ-037 Bench: out_ready held 0 for 6 cycles in HOLD -> outputs stable, in_ready=0; out_ready=1 -> one handshake, cmd_count +1.
REQ-038 Bench: rst_n pulsed low after the B byte -> all outputs 0; new sequence 3, 4, 3 -> out_result=7, cmd_count=1.
REQ-039 Bench: 256 completed commands -> cmd_count returns to 0.
